// File: rtl/exec_alu_cc.sv
// Execute-stage datapath: ALU, address adder, condition-code generation,
// the registered CC and the branch-condition test against an NZP mask.
module exec_alu_cc (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  aluop,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] imm,
  input  logic        imm_sel,
  input  logic [15:0] pc,
  input  logic [1:0]  adr_sel,
  input  logic [2:0]  nzp,
  input  logic        ld_cc,
  input  logic        ld_cc_ext,
  input  logic [2:0]  cc_ext,
  output logic [15:0] f,
  output logic [15:0] calc_addr,
  output logic [2:0]  gencc,
  output logic [2:0]  cc,
  output logic        branch_enable
);

  // One-hot N/Z/P classification of a 16-bit result.
  function automatic logic [2:0] classify(input logic [15:0] val);
    logic [2:0] code;
    if (val[15]) begin
      code = 3'b100;
    end else if (val != 16'h0000) begin
      code = 3'b001;
    end else begin
      code = 3'b010;
    end
    return code;
  endfunction

  logic [15:0] opnd_b_s;
  logic [15:0] base_s;
  logic [15:0] alu_s;
  logic [3:0]  shamt_s;
  logic [2:0]  cc_r;

  assign opnd_b_s = imm_sel ? imm : b;
  assign shamt_s  = opnd_b_s[3:0];

  // ALU operation decode.
  always_comb begin
    alu_s = 16'h0000;
    case (aluop)
      3'd0:    alu_s = a + opnd_b_s;
      3'd1:    alu_s = a & opnd_b_s;
      3'd2:    alu_s = ~a;
      3'd3:    alu_s = opnd_b_s;
      3'd4:    alu_s = a << shamt_s;
      3'd5:    alu_s = a >> shamt_s;
      3'd6:    alu_s = 16'($signed(a) >>> shamt_s);
      3'd7:    alu_s = 16'h0000;
      default: alu_s = 16'h0000;
    endcase
  end

  // Address base selection.
  always_comb begin
    base_s = 16'h0000;
    case (adr_sel)
      2'd0:    base_s = a;
      2'd1:    base_s = b;
      2'd2:    base_s = pc;
      2'd3:    base_s = 16'h0000;
      default: base_s = 16'h0000;
    endcase
  end

  // Local code has priority over the externally generated one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cc_r <= 3'b000;
    end else if (ld_cc) begin
      cc_r <= classify(alu_s);
    end else if (ld_cc_ext) begin
      cc_r <= cc_ext;
    end else begin
      cc_r <= cc_r;
    end
  end

  assign f             = alu_s;
  assign calc_addr     = imm + base_s;
  assign gencc         = classify(alu_s);
  assign cc            = cc_r;
  assign branch_enable = |(cc_r & nzp);

endmodule

// File: tb/tb_exec_alu_cc.sv
// Scoreboard bench for exec_alu_cc: a driver pushes model predictions,
// a monitor pops and compares them on the falling clock edge.
module tb_exec_alu_cc;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  aluop;
  logic [15:0] a, b, imm, pc;
  logic        imm_sel;
  logic [1:0]  adr_sel;
  logic [2:0]  nzp;
  logic        ld_cc, ld_cc_ext;
  logic [2:0]  cc_ext;
  logic [15:0] f, calc_addr;
  logic [2:0]  gencc, cc;
  logic        branch_enable;

  exec_alu_cc dut (
    .clk(clk), .reset(reset), .aluop(aluop), .a(a), .b(b), .imm(imm),
    .imm_sel(imm_sel), .pc(pc), .adr_sel(adr_sel), .nzp(nzp),
    .ld_cc(ld_cc), .ld_cc_ext(ld_cc_ext), .cc_ext(cc_ext),
    .f(f), .calc_addr(calc_addr), .gencc(gencc), .cc(cc),
    .branch_enable(branch_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        reset;
    logic [2:0]  aluop;
    logic [15:0] a, b, imm, pc;
    logic        imm_sel;
    logic [1:0]  adr_sel;
    logic [2:0]  nzp;
    logic        ld_cc, ld_cc_ext;
    logic [2:0]  cc_ext;
  } stim_t;

  typedef struct {
    logic [15:0] f, addr;
    logic [2:0]  gencc, cc;
    logic        be;
    bit          has_spec;
    logic [15:0] spec_f, spec_addr;
  } exp_t;

  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  stim_t prev;
  logic [2:0] cc_m;

  // Reference ALU from plain integer arithmetic.
  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    int ux, uy, p, sx, r;
    ux = int'(x);
    uy = int'(y);
    p  = 1 << (uy % 16);
    r  = 0;
    case (op)
      3'd0: r = (ux + uy) % 65536;
      3'd1: r = int'(x & y);
      3'd2: r = 65535 - ux;
      3'd3: r = uy;
      3'd4: r = (ux * p) % 65536;
      3'd5: r = ux / p;
      3'd6: begin
        sx = (ux >= 32768) ? ux - 65536 : ux;
        if (sx < 0) r = -((-sx + p - 1) / p);
        else        r = sx / p;
        if (r < 0) r = r + 65536;
      end
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic logic [2:0] ref_cc(input logic [15:0] v);
    int uv;
    uv = int'(v);
    if (uv >= 32768) return 3'b100;
    else if (uv != 0) return 3'b001;
    else return 3'b010;
  endfunction

  function automatic logic [15:0] ref_addr(input stim_t s);
    int base, r;
    case (s.adr_sel)
      2'd0: base = int'(s.a);
      2'd1: base = int'(s.b);
      2'd2: base = int'(s.pc);
      default: base = 0;
    endcase
    r = (int'(s.imm) + base) % 65536;
    return r[15:0];
  endfunction

  function automatic logic [15:0] opnd(input stim_t s);
    return s.imm_sel ? s.imm : s.b;
  endfunction

  task automatic apply(input stim_t s, input bit has_spec, input logic [15:0] sf, input logic [15:0] sa);
    exp_t e;
    @(posedge clk);
    #1;
    if (prev.reset)          cc_m = 3'b000;
    else if (prev.ld_cc)     cc_m = ref_cc(ref_alu(prev.aluop, prev.a, opnd(prev)));
    else if (prev.ld_cc_ext) cc_m = prev.cc_ext;
    reset = s.reset; aluop = s.aluop; a = s.a; b = s.b; imm = s.imm; pc = s.pc;
    imm_sel = s.imm_sel; adr_sel = s.adr_sel; nzp = s.nzp;
    ld_cc = s.ld_cc; ld_cc_ext = s.ld_cc_ext; cc_ext = s.cc_ext;
    e.f        = ref_alu(s.aluop, s.a, opnd(s));
    e.addr     = ref_addr(s);
    e.gencc    = ref_cc(e.f);
    e.cc       = cc_m;
    e.be       = (cc_m & s.nzp) != 3'b000;
    e.has_spec = has_spec;
    e.spec_f   = sf;
    e.spec_addr = sa;
    sb.push_back(e);
    prev = s;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare outputs against the oldest prediction each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("f", f, e.f);
        check("calc_addr", calc_addr, e.addr);
        check("gencc", {13'd0, gencc}, {13'd0, e.gencc});
        check("cc", {13'd0, cc}, {13'd0, e.cc});
        check("branch_enable", {15'd0, branch_enable}, {15'd0, e.be});
        if (e.has_spec) begin
          check("spec_f", f, e.spec_f);
          check("spec_addr", calc_addr, e.spec_addr);
        end
      end
    end
  end

  function automatic stim_t zero_stim();
    stim_t s;
    s = '{reset: 1'b0, aluop: 3'd0, a: 16'h0000, b: 16'h0000, imm: 16'h0000,
          pc: 16'h0000, imm_sel: 1'b0, adr_sel: 2'd0, nzp: 3'b000,
          ld_cc: 1'b0, ld_cc_ext: 1'b0, cc_ext: 3'b000};
    return s;
  endfunction

  initial begin
    stim_t s;
    prev = zero_stim();
    prev.reset = 1'b1;
    cc_m = 3'b000;
    reset = 1'b1; aluop = 3'd0; a = 16'h0000; b = 16'h0000; imm = 16'h0000;
    pc = 16'h0000; imm_sel = 1'b0; adr_sel = 2'd0; nzp = 3'b000;
    ld_cc = 1'b0; ld_cc_ext = 1'b0; cc_ext = 3'b000;

    // Reset held with ld_cc: cc stays zero for every mask.
    for (int i = 0; i < 8; i++) begin
      s = zero_stim(); s.reset = 1'b1; s.ld_cc = 1'b1; s.nzp = 3'(i); s.aluop = 3'd2;
      apply(s, 1'b0, 16'h0000, 16'h0000);
    end

    // Overflowing add, then load and test the N flag.
    s = zero_stim(); s.a = 16'h7FFF; s.b = 16'h0001; s.ld_cc = 1'b1; s.nzp = 3'b100;
    apply(s, 1'b1, 16'h8000, 16'h7FFF);
    s.ld_cc = 1'b0;
    apply(s, 1'b1, 16'h8000, 16'h7FFF);
    s.nzp = 3'b011;
    apply(s, 1'b1, 16'h8000, 16'h7FFF);

    // Shifts by immediate.
    s = zero_stim(); s.imm_sel = 1'b1; s.imm = 16'h0004; s.a = 16'h8000; s.aluop = 3'd6;
    apply(s, 1'b1, 16'hF800, 16'h8004);
    s.aluop = 3'd5;
    apply(s, 1'b1, 16'h0800, 16'h8004);
    s.aluop = 3'd4; s.a = 16'h0001; s.imm = 16'h000F;
    apply(s, 1'b1, 16'h8000, 16'h0010);

    // AND / NOT / PASS.
    s = zero_stim(); s.aluop = 3'd1; s.a = 16'h00F0; s.b = 16'h0F0F;
    apply(s, 1'b1, 16'h0000, 16'h00F0);
    s.aluop = 3'd2;
    apply(s, 1'b1, 16'hFF0F, 16'h00F0);
    s.aluop = 3'd3; s.b = 16'h1234;
    apply(s, 1'b1, 16'h1234, 16'h00F0);

    // Address base selection with a negative offset.
    for (int i = 0; i < 4; i++) begin
      logic [15:0] ea [4];
      ea[0] = 16'h0FFE; ea[1] = 16'h1FFE; ea[2] = 16'h2FFE; ea[3] = 16'hFFFE;
      s = zero_stim(); s.imm = 16'hFFFE; s.pc = 16'h3000; s.a = 16'h1000; s.b = 16'h2000;
      s.adr_sel = 2'(i); s.aluop = 3'd7;
      apply(s, 1'b1, 16'h0000, ea[i]);
    end

    // ld_cc beats ld_cc_ext; then ext alone; then hold.
    s = zero_stim(); s.a = 16'h0005; s.aluop = 3'd3; s.b = 16'h0005;
    s.ld_cc = 1'b1; s.ld_cc_ext = 1'b1; s.cc_ext = 3'b100; s.nzp = 3'b111;
    apply(s, 1'b0, 16'h0000, 16'h0000);
    s.ld_cc = 1'b0;
    apply(s, 1'b0, 16'h0000, 16'h0000);
    s.ld_cc_ext = 1'b0;
    apply(s, 1'b0, 16'h0000, 16'h0000);
    apply(s, 1'b0, 16'h0000, 16'h0000);
    s.ld_cc_ext = 1'b1; s.cc_ext = 3'b101;
    apply(s, 1'b0, 16'h0000, 16'h0000);
    s.ld_cc_ext = 1'b0; s.nzp = 3'b001;
    apply(s, 1'b0, 16'h0000, 16'h0000);

    // Zero result loaded, then reset overrides ld_cc.
    s = zero_stim(); s.aluop = 3'd7; s.ld_cc = 1'b1; s.nzp = 3'b010;
    apply(s, 1'b0, 16'h0000, 16'h0000);
    s.reset = 1'b1; s.nzp = 3'b111;
    apply(s, 1'b0, 16'h0000, 16'h0000);
    s.reset = 1'b0; s.ld_cc = 1'b0;
    apply(s, 1'b0, 16'h0000, 16'h0000);
    apply(s, 1'b0, 16'h0000, 16'h0000);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      s.reset     = ($urandom_range(0, 24) == 0);
      s.aluop     = 3'($urandom_range(0, 7));
      s.a         = 16'($urandom);
      s.b         = 16'($urandom);
      s.imm       = 16'($urandom);
      s.pc        = 16'($urandom);
      s.imm_sel   = 1'($urandom_range(0, 1));
      s.adr_sel   = 2'($urandom_range(0, 3));
      s.nzp       = 3'($urandom_range(0, 7));
      s.ld_cc     = ($urandom_range(0, 2) == 0);
      s.ld_cc_ext = ($urandom_range(0, 2) == 0);
      s.cc_ext    = 3'($urandom_range(0, 7));
      apply(s, 1'b0, 16'h0000, 16'h0000);
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
